// File: rtl/if_stage_unit.sv
// ---------------------------------------------------------------------------
// if_stage_unit
//   Instruction-fetch stage plus IF/ID pipeline register.
//   The stage holds the program counter and fetches from instruction memory
//   over a level req/ready handshake. It obeys the hazard-unit stall (freeze)
//   and the EXE-stage branch redirect. A skid buffer catches a fetch that
//   completes while the stage is frozen, so that instruction is not lost.
//
// Parameters
//   RESET_PC      PC value after reset
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   freeze        stall: hold PC and IF/ID register
//   branch_taken  redirect from EXE; overrides freeze and a same-cycle fetch
//   branch_addr   redirect target
//   imem_req      fetch request (level, held until imem_ready)
//   imem_addr     fetch address, stable while a request is pending
//   imem_ready    memory accepts the request and returns data this cycle
//   imem_rdata    fetched instruction
//   if_id_pc      address of the IF/ID instruction + 4
//   if_id_instr   IF/ID instruction, 0 when invalid
//   if_id_valid   IF/ID register holds a real instruction
//   fetch_busy    stage is not in the FETCH state
// ---------------------------------------------------------------------------
module if_stage_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic        req_en;
    logic [31:0] pc;
    logic [31:0] fetch_addr;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic [31:0] if_id_pc_p1;
    logic [31:0] if_id_instr_p1;
    logic        vld_p1;
    logic        xfer;
    logic [31:0] fetch_pc4;

    // PC arithmetic wraps naturally at 32 bits; no alignment checking.
    function automatic logic [31:0] pc_inc(input logic [31:0] a);
        return a + 32'd4;
    endfunction

    // req_en keeps the request low while reset is asserted and raises it
    // on the first clock after release.
    assign imem_req   = req_en && (state != HOLD);
    assign imem_addr  = fetch_addr;
    assign xfer       = imem_req && imem_ready;
    assign fetch_pc4  = pc_inc(fetch_addr);
    assign fetch_busy = (state != FETCH);

    // ---- IF -> IF/ID boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FETCH;
            req_en         <= 1'b0;
            pc             <= RESET_PC;
            fetch_addr     <= RESET_PC;
            skid_instr     <= 32'd0;
            skid_pc4       <= 32'd0;
            if_id_pc_p1    <= 32'd0;
            if_id_instr_p1 <= 32'd0;
            vld_p1         <= 1'b0;
        end else begin
            req_en <= 1'b1;
            if (branch_taken) begin
                // Redirect wins over freeze and drops any same-cycle data.
                pc             <= branch_addr;
                vld_p1         <= 1'b0;
                if_id_instr_p1 <= 32'd0;
                skid_instr     <= 32'd0;
                skid_pc4       <= 32'd0;
                case (state)
                    FETCH: begin
                        // An outstanding request must complete before the
                        // address may change, so its data gets dropped later.
                        if (imem_req && !imem_ready) begin
                            state <= DISCARD;
                        end else begin
                            fetch_addr <= branch_addr;
                            state      <= FETCH;
                        end
                    end
                    HOLD: begin
                        fetch_addr <= branch_addr;
                        state      <= FETCH;
                    end
                    DISCARD: begin
                        // Stale request still pending; only the target moves.
                        if (xfer) begin
                            fetch_addr <= branch_addr;
                            state      <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end else begin
                case (state)
                    FETCH: begin
                        if (xfer && !freeze) begin
                            if_id_pc_p1    <= fetch_pc4;
                            if_id_instr_p1 <= imem_rdata;
                            vld_p1         <= 1'b1;
                            pc             <= fetch_pc4;
                            fetch_addr     <= fetch_pc4;
                        end else if (xfer && freeze) begin
                            skid_pc4   <= fetch_pc4;
                            skid_instr <= imem_rdata;
                            pc         <= fetch_pc4;
                            state      <= HOLD;
                        end else if (!freeze) begin
                            vld_p1         <= 1'b0;
                            if_id_instr_p1 <= 32'd0;
                        end
                    end
                    HOLD: begin
                        if (!freeze) begin
                            if_id_pc_p1    <= skid_pc4;
                            if_id_instr_p1 <= skid_instr;
                            vld_p1         <= 1'b1;
                            fetch_addr     <= pc;
                            state          <= FETCH;
                        end
                    end
                    DISCARD: begin
                        if (xfer) begin
                            fetch_addr <= pc;
                            state      <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

    assign if_id_pc    = if_id_pc_p1;
    assign if_id_instr = if_id_instr_p1;
    assign if_id_valid = vld_p1;

endmodule

// File: doc/if_stage_unit.md
# if_stage_unit

Instruction-fetch stage and IF/ID pipeline register of the five-stage ARM core. Holds the program counter and issues fetch requests to instruction memory over a req/ready handshake. Presents fetched instructions to the ID stage. Obeys the hazard unit's stall signal (`freeze`) and the EXE-stage branch redirect; a skid buffer keeps an in-flight fetch from being lost while the stage is frozen.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `freeze`  in  1  stall from hazard detection unit; hold PC and IF/ID register
- `branch_taken`  in  1  EXE-stage redirect; overrides `freeze`
- `branch_addr`  in  32  redirect target (word aligned)
- `imem_req`  out  1  fetch request, level; held until `imem_ready`
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1
- `imem_ready`  in  1  memory accepts and returns data this cycle
- `imem_rdata`  in  32  instruction, valid when `imem_req && imem_ready`
- `if_id_pc`  out  32  address of instruction + 4
- `if_id_instr`  out  32  instruction to ID; 0 when invalid
- `if_id_valid`  out  1  IF/ID register holds a real instruction
- `fetch_busy`  out  1  1 when not in FETCH state (debug/perf)

## Operation
- Registers: `pc`, `fetch_addr`, 32-bit skid buffer `skid_instr`, `skid_pc4`, IF/ID register, 2-bit state.
- Transfer: `imem_req && imem_ready`. `imem_addr` = `fetch_addr`.
- States:
  - FETCH: `imem_req`=1.
    - Transfer with `freeze`=0: IF/ID <= {`fetch_addr`+4, `imem_rdata`, valid=1}; `pc`, `fetch_addr` <= `fetch_addr`+4.
    - Transfer with `freeze`=1: skid <= {`fetch_addr`+4, `imem_rdata`}; `pc` <= `fetch_addr`+4; IF/ID holds; go HOLD.
    - No transfer with `freeze`=0: IF/ID valid <= 0, instr <= 0 (bubble).
    - No transfer with `freeze`=1: IF/ID holds.
  - HOLD: `imem_req`=0; IF/ID holds while `freeze`=1. When `freeze`=0: IF/ID <= skid, valid=1; `fetch_addr` <= `pc`; go FETCH.
  - DISCARD: `imem_req`=1 at the stale `fetch_addr`. On transfer, drop the data; `fetch_addr` <= `pc`; go FETCH. IF/ID is invalid throughout.
- Branch (`branch_taken`=1, any state):
  - `pc` <= `branch_addr`; IF/ID valid <= 0, instr <= 0; skid discarded.
  - FETCH with no transfer this cycle: go DISCARD, since the outstanding request must complete.
  - FETCH with transfer, or HOLD: `fetch_addr` <= `branch_addr`; go/stay FETCH.
  - DISCARD: update `pc` only. The newest target wins.
- Branch has priority over `freeze` and over a same-cycle transfer, whose data is dropped.
- PC arithmetic: 32-bit, +4, wraps 32'hFFFF_FFFC -> 0. No alignment checking.
- `fetch_busy` = (state != FETCH).

## Timing
- Reset (async assert, sync-safe deassert):
  - `pc` = `fetch_addr` = `RESET_PC`; state FETCH.
  - `if_id_pc` = 0, `if_id_instr` = 0, `if_id_valid` = 0; skid = 0.
  - `imem_req` = 1 from the first cycle after deassert. `fetch_busy` = 0.
- Reset mid-fetch abandons the request. Memory must tolerate `imem_req` dropping without ready.
- Latency: transfer in cycle N -> IF/ID outputs valid in cycle N+1.
- Throughput: 1 instruction/cycle with `imem_ready` tied 1 and no freeze/branch.
- HOLD release: `freeze` falls in cycle N -> IF/ID updated N+1; next request issued N+1.
- Branch in cycle N: IF/ID invalid N+1; target request issued N+1, or after the stale transfer completes (DISCARD).
- `imem_addr` never changes while `imem_req`=1 and `imem_ready`=0.

## Test plan
- Reset then `imem_ready`=1, 4 cycles: `imem_addr` 0,4,8,12; `if_id_pc` 4,8,12,16 one cycle later, valid=1.
- `freeze`=1 for 3 cycles while a transfer of 32'hE3A0_1005 at addr 8 occurs: IF/ID unchanged, `imem_req`=0, state HOLD. Release: `if_id_instr`=32'hE3A0_1005, `if_id_pc`=12, next `imem_addr`=12.
- `imem_ready`=0 for 2 cycles at addr 16, no freeze: `if_id_valid`=0 both cycles, `imem_addr` stays 16.
- `branch_taken`=1, `branch_addr`=32'h100, while addr 20 waits on ready: DISCARD, `imem_addr` stays 20 until ready; data dropped; next `imem_addr`=32'h100, `if_id_valid`=0 until that data returns.
- `branch_taken` and `freeze` both 1 in HOLD: skid dropped, `if_id_valid`=0, next request to `branch_addr`.
- `rst_n` asserted mid-HOLD: all outputs zero immediately; after release `imem_addr`=`RESET_PC`.
